// File: rtl/fifo_drain_ctrl.sv
// Drains 32-bit words from the asymmetric flushable FIFO into a local word buffer and sequences flushes.
// Define FLUSH_TIMEOUT_EN to add the idle-timeout automatic flush; the default build has it disabled.
//
// state  | meaning
// IDLE   | normal rd traffic while there is buffer room; accepts flush requests
// FDRAIN | reads stopped; waits for the in-flight word and enough buffer room
// FLUSH  | flush_req held until the FIFO reports flush_done
// FWAIT  | absorbs the last capture, drains the buffer, then pulses flush_ack
module fifo_drain_ctrl #(
  parameter int WORD_W    = 32,
  parameter int BUF_DEPTH = 8,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vld_rd_data_i,
  input  logic              empty_i,
  input  logic              flush_done_i,
  input  logic [WORD_W-1:0] rd_data_i,
  output logic              rd_o,
  output logic              flush_req_o,
  input  logic              flush_cmd_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [WORD_W-1:0] m_data_o,
  output logic              flush_ack_o,
  output logic              flush_busy_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W:0]   RD_LIM    = (CNT_W + 1)'(BUF_DEPTH - 2);
  localparam logic [CNT_W-1:0] DRAIN_LIM = CNT_W'(BUF_DEPTH - 5);

  if (BUF_DEPTH < 6) begin : g_depth_chk
    $error("fifo_drain_ctrl: BUF_DEPTH must be at least 6");
  end
  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("fifo_drain_ctrl: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, FDRAIN, FLUSH, FWAIT} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              pop_d_q;
  logic              pend_q, pend_d;
  logic              fifo_pop, deq, timeout_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef FLUSH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            idle_cond;

  // Partial data sitting in the FIFO with nothing else going on.
  always_comb begin
    idle_cond   = (state_q == IDLE) && !empty_i && !vld_rd_data_i && (occ_q == '0);
    timeout_hit = idle_cond && (idle_cnt_q == TO_W'(TIMEOUT - 1));
    idle_cnt_d  = '0;
    if (idle_cond && !timeout_hit) idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign flush_busy_o = (state_q != IDLE);
  assign fifo_pop     = (rd_o | flush_req_o) & ~empty_i;
  assign m_valid_o    = (occ_q != '0);
  assign m_data_o     = m_valid_o ? buf_mem[head_q] : '0;
  assign deq          = m_valid_o & m_ready_i;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    rd_o        = 1'b0;
    flush_req_o = 1'b0;
    flush_ack_o = 1'b0;
    case (state_q)
      IDLE: begin
        // Counting the in-flight word keeps one slot of margin for any capture.
        rd_o = vld_rd_data_i && (({1'b0, occ_q} + {{CNT_W{1'b0}}, pop_d_q}) <= RD_LIM);
        if (flush_cmd_i || pend_q || timeout_hit) begin
          state_d = FDRAIN;
          pend_d  = 1'b0;
        end
      end
      FDRAIN: begin
        if (!pop_d_q && (occ_q <= DRAIN_LIM)) begin
          if (empty_i) begin
            flush_ack_o = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_req_o = 1'b1;
        if (flush_done_i) state_d = FWAIT;
      end
      FWAIT: begin
        if (!pop_d_q && (occ_q == '0)) begin
          flush_ack_o = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_cmd_i && flush_busy_o) pend_d = 1'b1;
  end

  always_comb begin
    head_d = deq ? ptr_inc(head_q) : head_q;
    tail_d = pop_d_q ? ptr_inc(tail_q) : tail_q;
    occ_d  = occ_q;
    case ({pop_d_q, deq})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (pop_d_q) buf_mem[tail_q] <= rd_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      pop_d_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      pop_d_q <= fifo_pop;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl: a small FIFO responder drives the read side,
// expected words are queued at stimulus time and checked by a monitor on each accepted word.
`timescale 1ns/1ps
module tb_fifo_drain_ctrl;
  localparam int WORD_W    = 32;
  localparam int BUF_DEPTH = 8;
  localparam int TIMEOUT   = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              vld_rd_data_i, empty_i, flush_done_i, flush_cmd_i, m_ready_i;
  logic [WORD_W-1:0] rd_data_i;
  logic              rd_o, flush_req_o, m_valid_o, flush_ack_o, flush_busy_o;
  logic [WORD_W-1:0] m_data_o;

  fifo_drain_ctrl #(.WORD_W(WORD_W), .BUF_DEPTH(BUF_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .vld_rd_data_i(vld_rd_data_i), .empty_i(empty_i),
    .flush_done_i(flush_done_i), .rd_data_i(rd_data_i), .rd_o(rd_o), .flush_req_o(flush_req_o),
    .flush_cmd_i(flush_cmd_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .flush_ack_o(flush_ack_o), .flush_busy_o(flush_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] fifo_words[$];
  int          part_bits = 0;
  logic [31:0] part_val = '0;
  int pop_cnt = 0, req_cnt = 0, ack_cnt = 0, cyc = 0, last_acc_cyc = 0;
  int ack_cycs[$];
  bit prev_req = 1'b0, prev_done = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic upd_flags();
    vld_rd_data_i = (fifo_words.size() > 0);
    empty_i       = (fifo_words.size() == 0) && (part_bits == 0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic load(input logic [31:0] w, input bit expect_it);
    fifo_words.push_back(w);
    if (expect_it) exp_q.push_back(w);
    upd_flags();
  endtask

  task automatic wait_quiet(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      tick();
      if (!m_valid_o && !flush_busy_o && !rd_o && fifo_words.size() == 0 &&
          part_bits == 0 && exp_q.size() == 0) break;
    end
    n_cmp++;
    if (i == 200) begin
      n_err++;
      $display("FAIL %s: waited 200 cycles, required buffer and FIFO idle", name);
    end
    repeat (3) tick();
  endtask

  // FIFO read-side responder: pop seen at negedge, word returned the next cycle.
  initial begin : fifo_model
    bit pop, fr;
    forever begin
      @(negedge clk_i);
      pop = (rd_o || flush_req_o) && !empty_i;
      fr  = flush_req_o;
      @(posedge clk_i);
      #1;
      if (pop) begin
        pop_cnt++;
        if (fifo_words.size() > 0) rd_data_i = fifo_words.pop_front();
        else begin
          rd_data_i = part_val;
          part_bits = 0;
          part_val  = '0;
        end
      end
      flush_done_i = fr && (fifo_words.size() == 0) && (part_bits == 0) && !flush_done_i;
      upd_flags();
    end
  end

  // Monitor: scoreboard compare on every accepted word, plus flush_req hold check.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_req  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (m_valid_o && m_ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL data_unexpected: got %0h, required no word", m_data_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (m_data_o !== e) begin
            n_err++;
            $display("FAIL data_order: got %0h, required %0h", m_data_o, e);
          end
        end
        last_acc_cyc = cyc;
      end
      if (prev_req && !flush_req_o) begin
        n_cmp++;
        if (!prev_done) begin
          n_err++;
          $display("FAIL flush_req_hold: dropped with flush_done=%0b, required 1", prev_done);
        end
      end
      if (flush_req_o) req_cnt++;
      if (flush_ack_o) begin
        ack_cnt++;
        ack_cycs.push_back(cyc);
      end
      prev_req  = flush_req_o;
      prev_done = flush_done_i;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  int s, a0, r0, p0, n0, ack_at, busy_bad, first_req;
  bit got;

  initial begin
    rst_i = 1'b1; rd_data_i = '0; flush_done_i = 1'b0; flush_cmd_i = 1'b0; m_ready_i = 1'b0;
    upd_flags();
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_rd", rd_o, 0);
    check("rst_flush_req", flush_req_o, 0);
    check("rst_m_valid", m_valid_o, 0);
    check("rst_m_data", m_data_o, 0);
    check("rst_flush_ack", flush_ack_o, 0);
    check("rst_flush_busy", flush_busy_o, 0);

    // Stream of three words with downstream always ready.
    tick();
    m_ready_i = 1'b1;
    a0 = ack_cnt;
    load(32'h11111111, 1); load(32'h22222222, 1); load(32'h33333333, 1);
    s = cyc;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk_i);
      if (m_valid_o) got = 1;
    end
    check("stream_first_valid_cycle", cyc - s, 2);
    wait_quiet("stream_drain");
    check("stream_no_ack", ack_cnt - a0, 0);

    // Backpressure: rd must stop with 7 words buffered or in flight.
    m_ready_i = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) load(32'hB0000000 + i, 1);
    repeat (20) tick();
    @(negedge clk_i);
    check("bp_pop_count", pop_cnt - p0, 7);
    check("bp_rd_stopped", rd_o, 0);
    check("bp_m_valid", m_valid_o, 1);
    tick();
    m_ready_i = 1'b1;
    wait_quiet("bp_drain");

    // Flush of 12 bits of partial data.
    a0 = ack_cnt; r0 = req_cnt;
    part_bits = 12; part_val = 32'h00000ABC; upd_flags();
    exp_q.push_back(32'h00000ABC);
    flush_cmd_i = 1'b1;
    s = cyc;
    tick();
    flush_cmd_i = 1'b0;
    busy_bad = 0; got = 0; ack_at = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk_i);
      if (!flush_busy_o) busy_bad++;
      if (flush_ack_o) begin
        got = 1;
        ack_at = cyc;
      end
    end
    check("partial_ack_seen", got, 1);
    check("partial_ack_after_accept", ack_at - last_acc_cyc, 1);
    check("partial_busy_low_cycles", busy_bad, 0);
    wait_quiet("partial_flush");
    check("partial_req_cycles", req_cnt - r0, 2);
    check("partial_ack_count", ack_cnt - a0, 1);

    // Flush with an empty FIFO: no flush_req, quick ack.
    a0 = ack_cnt; r0 = req_cnt;
    flush_cmd_i = 1'b1;
    s = cyc;
    tick();
    flush_cmd_i = 1'b0;
    got = 0; ack_at = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk_i);
      if (flush_ack_o) begin
        got = 1;
        ack_at = cyc;
      end
    end
    check("empty_ack_within_2", (ack_at - s >= 1) && (ack_at - s <= 2), 1);
    wait_quiet("empty_flush");
    check("empty_no_flush_req", req_cnt - r0, 0);

    // Second flush_cmd during FLUSH collapses into one pending flush.
    a0 = ack_cnt; r0 = req_cnt; n0 = ack_cycs.size();
    part_bits = 8; part_val = 32'h0000005A; upd_flags();
    exp_q.push_back(32'h0000005A);
    flush_cmd_i = 1'b1;
    tick();
    flush_cmd_i = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (flush_req_o) got = 1;
    end
    check("second_req_seen", got, 1);
    tick();
    flush_cmd_i = 1'b1;
    tick();
    flush_cmd_i = 1'b0;
    repeat (20) tick();
    check("second_ack_count", ack_cnt - a0, 2);
    if (ack_cycs.size() >= n0 + 2)
      check("second_ack_gap", ack_cycs[n0+1] - ack_cycs[n0], 2);
    check("second_req_cycles", req_cnt - r0, 2);
    wait_quiet("second_flush");

    // Idle partial data with no activity.
    r0 = req_cnt;
    part_bits = 8; part_val = 32'h000000C3; upd_flags();
    exp_q.push_back(32'h000000C3);
    s = cyc;
`ifdef FLUSH_TIMEOUT_EN
    got = 0; first_req = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      if (flush_req_o) begin
        got = 1;
        first_req = cyc;
      end
    end
    check("timeout_req_seen", got, 1);
    check("timeout_req_idle_cycle", first_req - s + 1, TIMEOUT + 2);
    wait_quiet("timeout_flush");
`else
    repeat (40) tick();
    check("no_timeout_req", req_cnt - r0, 0);
    flush_cmd_i = 1'b1;
    tick();
    flush_cmd_i = 1'b0;
    wait_quiet("manual_flush_after_idle");
`endif

    // Reset mid-operation discards buffered words.
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) load(32'hDEAD0000 + i, 0);
    repeat (6) tick();
    rst_i = 1'b1;
    fifo_words.delete();
    part_bits = 0; part_val = '0; flush_done_i = 1'b0;
    upd_flags();
    tick(); tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_m_valid", m_valid_o, 0);
    check("midrst_m_data", m_data_o, 0);
    check("midrst_flush_busy", flush_busy_o, 0);
    tick();
    m_ready_i = 1'b1;
    load(32'hCAFE0001, 1); load(32'hCAFE0002, 1);
    wait_quiet("after_reset_stream");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
- Downstream consumer of the asymmetric 4-bit-in / 32-bit-out flushable FIFO.
- Issues `rd` whenever a full 32-bit word is available and there is room for it. Issues and holds `flush_req` on an external flush command, or on an idle timeout when that feature is compiled in.
- Captures every returned word into a local word buffer and presents the words on a valid/ready stream to the next stage.
- Pulses `flush_ack` once every flushed word has been accepted downstream.

Parameters:
- WORD_W, 32, read-side word width (matches the FIFO read width).
- BUF_DEPTH, 8, word-buffer entries; must be ≥ 6 (4 words of FIFO capacity, 1 in flight, 1 margin).
- TIMEOUT, 16, idle cycles with partial data before an automatic flush (used only with the optional feature).
- CNT_W, $clog2(BUF_DEPTH+1), width of the occupancy counter.

Ports:
- clk  in  1  clock, all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- vld_rd_data  in  1  FIFO holds ≥ 32 bits.
- empty  in  1  FIFO empty flag.
- flush_done  in  1  FIFO flush complete.
- rd_data  in  WORD_W  FIFO read word; valid the cycle after a pop.
- rd  out  1  read request to FIFO.
- flush_req  out  1  flush request to FIFO.
- flush_cmd  in  1  single-cycle request from control to flush the FIFO.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  WORD_W  output word, head of buffer.
- flush_ack  out  1  one-cycle pulse: flush fully delivered.
- flush_busy  out  1  high from flush acceptance until the `flush_ack` cycle, inclusive.

Behaviour:
- Reset values: `rd`=0, `flush_req`=0, `m_valid`=0, `m_data`=0, `flush_ack`=0, `flush_busy`=0. Buffer empty, state IDLE, counters 0, pending-flush flag 0.
- Reset mid-operation discards buffer contents and any in-flight or pending flush immediately.
- FIFO pop model: a pop occurs in any cycle where (`rd` | `flush_req`) & !`empty`.
  - Register this as `pop_d`.
  - When `pop_d`=1, write `rd_data` into the buffer tail.
  - Capture has priority; the space rules below guarantee the buffer never overflows.
- Buffer: circular, BUF_DEPTH words.
  - `m_valid` = occupancy ≠ 0; `m_data` = head entry.
  - Pop the head on `m_valid` & `m_ready`.
  - Simultaneous capture and pop leaves occupancy unchanged.
- IDLE:
  - `rd` = `vld_rd_data` & (occupancy + `pop_d` ≤ BUF_DEPTH−2).
  - A `flush_cmd`, or a pending flag set earlier, moves to FDRAIN next cycle.
  - `rd` is still permitted in the cycle `flush_cmd` is seen; that word is delivered before the flush words.
- FDRAIN: `rd`=0. Wait until `pop_d`=0 and occupancy ≤ BUF_DEPTH−5.
  - If `empty`=1: skip the FIFO flush, pulse `flush_ack`, go to IDLE. `flush_req` is never raised on an empty FIFO.
  - Otherwise go to FLUSH.
- FLUSH:
  - `flush_req`=1, held continuously until the cycle `flush_done`=1. Deassert next cycle, then go to FWAIT.
  - `rd`=0 throughout.
- FWAIT: absorb any final `pop_d` capture. When `pop_d`=0 and occupancy=0, pulse `flush_ack` for one cycle and go to IDLE.
- `flush_cmd` while `flush_busy`=1: latch into the pending flag and service it after return to IDLE. Multiple commands collapse to one.
- Zero-padded partial words from the FIFO are passed through unmodified.
- FIFO words written after the flush cycle arrive through normal `rd` traffic after `flush_ack`.

Optional Feature:
- Macro: FLUSH_TIMEOUT_EN.
- Defined:
  - An idle counter increments each IDLE cycle with !`empty` & !`vld_rd_data` & occupancy=0.
  - It clears on any other cycle.
  - Reaching TIMEOUT sets the pending flag, then the counter clears.
- Undefined: no counter, and flushes occur only via `flush_cmd`.

Test Plan:
- Stream: `vld_rd_data` high for 3 pops returning 0x11111111, 0x22222222, 0x33333333, with `m_ready`=1 → `m_data` shows those words in order, each one cycle after its capture; `flush_ack` stays 0.
- Backpressure: `m_ready`=0, `vld_rd_data`=1 continuously → `rd` stops after occupancy + in-flight reaches BUF_DEPTH−1 = 7 words; releasing `m_ready` drains all 7 words in order.
- Flush of partial data: FIFO holds 12 bits; pulse `flush_cmd` → `flush_req` held until `flush_done`; word 0x00000ABC delivered; `flush_ack` pulses one cycle after it is accepted; `flush_busy` high throughout.
- Flush with `empty`=1 at FDRAIN → `flush_req` never asserts; `flush_ack` pulses within 2 cycles.
- A second `flush_cmd` arriving during FLUSH → exactly two `flush_ack` pulses, and the second flush starts only after return to IDLE.
- FLUSH_TIMEOUT_EN defined, TIMEOUT=16, FIFO holding 8 bits with no activity → `flush_req` rises at idle cycle 16+2. Macro undefined, same stimulus → `flush_req` stays 0.
